// File: rtl/traffic_light_monitor.sv
// Monitor for the traffic light code bus: decodes the phase, checks legality,
// conflicts, phase order and dwell, repeats the lights and forces red on fault.
module traffic_light_monitor #(
  parameter int unsigned MIN_DWELL = 3,
  parameter int unsigned MAX_DWELL = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ns,
  input  logic [2:0] ew,
  input  logic [2:0] p_ns,
  input  logic [2:0] p_ew,
  input  logic       fault_clr,
  output logic [2:0] ns_o,
  output logic [2:0] ew_o,
  output logic [2:0] p_ns_o,
  output logic [2:0] p_ew_o,
  output logic [2:0] phase,
  output logic       phase_valid,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int unsigned DW = $clog2(MAX_DWELL + 2);

  localparam logic [2:0] C_RED = 3'b001;
  localparam logic [2:0] PH_NONE = 3'd7;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_ILLEGAL = 3'd1;
  localparam logic [2:0] FC_CONFL   = 3'd2;
  localparam logic [2:0] FC_SEQ     = 3'd3;
  localparam logic [2:0] FC_SHORT   = 3'd4;
  localparam logic [2:0] FC_TIMEOUT = 3'd5;

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          first_q, first_d;
  logic [2:0]    ns_o_q, ns_o_d;
  logic [2:0]    ew_o_q, ew_o_d;
  logic [2:0]    p_ns_o_q, p_ns_o_d;
  logic [2:0]    p_ew_o_q, p_ew_o_d;
  logic [2:0]    phase_q, phase_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;
  logic [2:0]    code_q, code_d;

  logic          illegal_c;
  logic          tuple_hit_c;
  logic [2:0]    tuple_ph_c;
  logic [2:0]    sync_fc_c;
  logic [2:0]    ph_next_c;
  logic [DW-1:0] dwell_inc_c;

  function automatic logic code_ok(input logic [2:0] c);
    return (c == 3'b001) || (c == 3'b010) || (c == 3'b011);
  endfunction

  // Decode the sampled tuple into a phase and classify code/conflict errors
  always_comb begin
    illegal_c   = !(code_ok(ns) && code_ok(ew) && code_ok(p_ns) && code_ok(p_ew));
    tuple_hit_c = 1'b1;
    tuple_ph_c  = PH_NONE;
    unique case ({ns, ew, p_ns, p_ew})
      12'b011_001_001_011: tuple_ph_c = 3'd0;
      12'b010_001_001_001: tuple_ph_c = 3'd1;
      12'b001_001_001_001: tuple_ph_c = 3'd2;
      12'b001_011_001_001: tuple_ph_c = 3'd3;
      12'b001_010_001_001: tuple_ph_c = 3'd4;
      12'b001_001_011_011: tuple_ph_c = 3'd5;
      default:             tuple_hit_c = 1'b0;
    endcase
    if (illegal_c) begin
      sync_fc_c = FC_ILLEGAL;
    end else if (!tuple_hit_c) begin
      sync_fc_c = FC_CONFL;
    end else begin
      sync_fc_c = FC_NONE;
    end
    ph_next_c   = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
    dwell_inc_c = (dwell_q == {DW{1'b1}}) ? dwell_q : dwell_q + DW'(1);
  end

  // Next-state, fault recording and output selection
  always_comb begin
    logic [2:0] fc_new;
    state_d  = state_q;
    dwell_d  = dwell_q;
    first_d  = first_q;
    fault_d  = fault_q;
    code_d   = code_q;
    ns_o_d   = ns;
    ew_o_d   = ew;
    p_ns_o_d = p_ns;
    p_ew_o_d = p_ew;
    phase_d  = tuple_ph_c;
    valid_d  = tuple_hit_c;
    fc_new   = FC_NONE;

    unique case (state_q)
      S_SYNC: begin
        fc_new = sync_fc_c;
        if (fc_new == FC_NONE && tuple_ph_c == 3'd0) begin
          state_d = S_RUN;
          dwell_d = DW'(1);
          first_d = 1'b1;
        end
      end
      S_RUN: begin
        fc_new = sync_fc_c;
        if (fc_new == FC_NONE) begin
          if (tuple_ph_c == phase_q) begin
            if (dwell_q >= DW'(MAX_DWELL)) begin
              fc_new = FC_TIMEOUT;
            end else begin
              dwell_d = dwell_inc_c;
            end
          end else if (tuple_ph_c == ph_next_c) begin
            if (dwell_q < DW'(MIN_DWELL) && !first_q) begin
              fc_new = FC_SHORT;
            end else begin
              dwell_d = DW'(1);
              first_d = 1'b0;
            end
          end else begin
            fc_new = FC_SEQ;
          end
        end
      end
      S_FAULT: begin
        if (fault_clr) begin
          // Clear wins; the same sample is re-checked for code errors only
          state_d = S_SYNC;
          fault_d = 1'b0;
          code_d  = FC_NONE;
          dwell_d = '0;
          fc_new  = sync_fc_c;
        end else begin
          ns_o_d   = C_RED;
          ew_o_d   = C_RED;
          p_ns_o_d = C_RED;
          p_ew_o_d = C_RED;
        end
      end
      default: state_d = S_SYNC;
    endcase

    if (fc_new != FC_NONE) begin
      state_d  = S_FAULT;
      fault_d  = 1'b1;
      code_d   = fc_new;
      ns_o_d   = C_RED;
      ew_o_d   = C_RED;
      p_ns_o_d = C_RED;
      p_ew_o_d = C_RED;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_SYNC;
      dwell_q  <= '0;
      first_q  <= 1'b0;
      ns_o_q   <= C_RED;
      ew_o_q   <= C_RED;
      p_ns_o_q <= C_RED;
      p_ew_o_q <= C_RED;
      phase_q  <= PH_NONE;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= FC_NONE;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      first_q  <= first_d;
      ns_o_q   <= ns_o_d;
      ew_o_q   <= ew_o_d;
      p_ns_o_q <= p_ns_o_d;
      p_ew_o_q <= p_ew_o_d;
      phase_q  <= phase_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end

  assign ns_o        = ns_o_q;
  assign ew_o        = ew_o_q;
  assign p_ns_o      = p_ns_o_q;
  assign p_ew_o      = p_ew_o_q;
  assign phase       = phase_q;
  assign phase_valid = valid_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed vector table, nominal rounds,
// and random traffic against a reference model.
module tb_traffic_light_monitor;

  localparam int MIN_D = 3;
  localparam int MAX_D = 3;

  localparam logic [11:0] T0   = 12'b011_001_001_011;
  localparam logic [11:0] T1   = 12'b010_001_001_001;
  localparam logic [11:0] T2   = 12'b001_001_001_001;
  localparam logic [11:0] T3   = 12'b001_011_001_001;
  localparam logic [11:0] T4   = 12'b001_010_001_001;
  localparam logic [11:0] T5   = 12'b001_001_011_011;
  localparam logic [11:0] CONF = 12'b011_011_001_001;
  localparam logic [11:0] ILL  = 12'b111_001_001_001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, fault_clr;
  logic [2:0] ns, ew, p_ns, p_ew;
  logic [2:0] ns_o, ew_o, p_ns_o, p_ew_o, phase, fault_code;
  logic       phase_valid, fault;

  int tests_run = 0;
  int tests_failed = 0;

  traffic_light_monitor #(.MIN_DWELL(3), .MAX_DWELL(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ns(ns), .ew(ew), .p_ns(p_ns), .p_ew(p_ew),
    .fault_clr(fault_clr),
    .ns_o(ns_o), .ew_o(ew_o), .p_ns_o(p_ns_o), .p_ew_o(p_ew_o),
    .phase(phase), .phase_valid(phase_valid),
    .fault(fault), .fault_code(fault_code)
  );

  logic [11:0] legal_t [6];

  // Reference model state: mode 0 = waiting for P0, 1 = running, 2 = faulted
  int          m_mode, m_last, m_dwell, m_phase, m_code;
  bit          m_first, m_valid, m_fault;
  logic [11:0] m_out;

  function automatic int lookup(input logic [11:0] b);
    for (int i = 0; i < 6; i++) if (b == legal_t[i]) return i;
    return -1;
  endfunction

  function automatic bit field_ok(input logic [2:0] f);
    return (f >= 3'd1) && (f <= 3'd3);
  endfunction

  task automatic model_step(input logic rstn, input logic clr, input logic [11:0] bus);
    int ph, viol;
    bit ill, cleared;
    if (!rstn) begin
      m_mode = 0; m_out = T2; m_phase = 7; m_valid = 0; m_fault = 0;
      m_code = 0; m_dwell = 0; m_first = 0; m_last = 0;
      return;
    end
    ph  = lookup(bus);
    ill = !(field_ok(bus[11:9]) && field_ok(bus[8:6]) && field_ok(bus[5:3]) && field_ok(bus[2:0]));
    viol = ill ? 1 : (ph < 0 ? 2 : 0);
    m_phase = (ph < 0) ? 7 : ph;
    m_valid = (ph >= 0);
    cleared = 0;
    if (m_mode == 2) begin
      if (!clr) begin
        m_out = T2;
        return;
      end
      m_mode = 0; m_fault = 0; m_code = 0; m_dwell = 0; cleared = 1;
    end
    if (viol == 0 && m_mode == 1) begin
      if (ph == m_last) begin
        if (m_dwell + 1 > MAX_D) viol = 5;
        else m_dwell = m_dwell + 1;
      end else if (ph == (m_last + 1) % 6) begin
        if (m_dwell < MIN_D && !m_first) viol = 4;
        else begin m_dwell = 1; m_first = 0; end
      end else begin
        viol = 3;
      end
    end else if (viol == 0 && m_mode == 0 && !cleared && ph == 0) begin
      m_mode = 1; m_dwell = 1; m_first = 1;
    end
    if (ph >= 0) m_last = ph;
    if (viol != 0) begin
      m_mode = 2; m_fault = 1; m_code = viol; m_out = T2;
    end else begin
      m_out = bus;
    end
  endtask

  function automatic logic [19:0] dut_vec();
    return {ns_o, ew_o, p_ns_o, p_ew_o, phase, phase_valid, fault, fault_code};
  endfunction

  function automatic logic [19:0] exp_vec(input logic [11:0] bus, input logic red,
                                          input logic [2:0] ph, input logic v,
                                          input logic f, input logic [2:0] c);
    return {(red ? T2 : bus), ph, v, f, c};
  endfunction

  task automatic check(input string name, input logic [19:0] exp);
    logic [19:0] got;
    got = dut_vec();
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %05h expected %05h", name, got, exp);
    end
  endtask

  // Apply one sample, advance one edge, compare against the model
  task automatic drive(input logic rstn, input logic clr, input logic [11:0] bus);
    rst_n = rstn;
    fault_clr = clr;
    {ns, ew, p_ns, p_ew} = bus;
    @(posedge clk);
    #1;
    model_step(rstn, clr, bus);
    check("model", {m_out, 3'(m_phase), m_valid, m_fault, 3'(m_code)});
  endtask

  typedef struct {
    logic        rstn;
    logic        clr;
    logic [11:0] bus;
    logic [2:0]  ph;
    logic        v;
    logic        f;
    logic [2:0]  c;
    logic        red;
  } vec_t;

  vec_t tbl[$];

  task automatic addn(input int n, input logic rstn, input logic clr, input logic [11:0] bus,
                      input logic [2:0] ph, input logic v, input logic f,
                      input logic [2:0] c, input logic red);
    vec_t e;
    e.rstn = rstn; e.clr = clr; e.bus = bus; e.ph = ph;
    e.v = v; e.f = f; e.c = c; e.red = red;
    for (int i = 0; i < n; i++) tbl.push_back(e);
  endtask

  initial begin
    legal_t[0] = T0; legal_t[1] = T1; legal_t[2] = T2;
    legal_t[3] = T3; legal_t[4] = T4; legal_t[5] = T5;
    rst_n = 1'b0; fault_clr = 1'b0;
    {ns, ew, p_ns, p_ew} = T2;

    // Nominal: reset then two full rounds of P0..P5 at 3 cycles each
    drive(1'b0, 1'b0, T2);
    drive(1'b0, 1'b0, T2);
    check("reset", exp_vec(T2, 1'b1, 3'd7, 1'b0, 1'b0, 3'd0));
    for (int k = 0; k < 36; k++) begin
      drive(1'b1, 1'b0, legal_t[(k / 3) % 6]);
      check($sformatf("nominal%0d", k),
            exp_vec(legal_t[(k / 3) % 6], 1'b0, 3'((k / 3) % 6), 1'b1, 1'b0, 3'd0));
    end

    // Directed vector table
    addn(2,  0, 0, T2,   7, 0, 0, 0, 1);
    addn(1,  1, 0, T0,   0, 1, 0, 0, 0);
    addn(1,  1, 1, T0,   0, 1, 0, 0, 0);
    addn(1,  1, 0, T0,   0, 1, 0, 0, 0);
    addn(3,  1, 0, T1,   1, 1, 0, 0, 0);
    addn(11, 1, 0, CONF, 7, 0, 1, 2, 1);
    addn(3,  1, 1, T2,   2, 1, 0, 0, 0);
    addn(1,  1, 0, T3,   3, 1, 0, 0, 0);
    addn(1,  1, 0, T0,   0, 1, 0, 0, 0);
    addn(3,  1, 0, T1,   1, 1, 0, 0, 0);
    addn(3,  1, 0, T3,   3, 1, 1, 3, 1);
    addn(1,  1, 1, T3,   3, 1, 0, 0, 0);
    addn(3,  1, 0, T0,   0, 1, 0, 0, 0);
    addn(1,  1, 0, T0,   0, 1, 1, 5, 1);
    addn(1,  1, 1, ILL,  7, 0, 1, 1, 1);
    addn(1,  1, 1, T2,   2, 1, 0, 0, 0);
    addn(3,  1, 0, T0,   0, 1, 0, 0, 0);
    addn(3,  1, 0, T1,   1, 1, 0, 0, 0);
    addn(3,  1, 0, T2,   2, 1, 0, 0, 0);
    addn(2,  1, 0, T3,   3, 1, 0, 0, 0);
    addn(1,  1, 0, T4,   4, 1, 1, 4, 1);
    addn(2,  1, 0, T3,   3, 1, 1, 4, 1);
    addn(1,  0, 1, T3,   7, 0, 0, 0, 1);
    addn(1,  1, 0, T0,   0, 1, 0, 0, 0);
    addn(1,  1, 0, T1,   1, 1, 0, 0, 0);
    addn(1,  1, 0, ILL,  7, 0, 1, 1, 1);
    addn(1,  0, 0, T2,   7, 0, 0, 0, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rstn, tbl[i].clr, tbl[i].bus);
      check($sformatf("vec%0d", i),
            exp_vec(tbl[i].bus, tbl[i].red, tbl[i].ph, tbl[i].v, tbl[i].f, tbl[i].c));
    end

    // Random traffic: mostly well-formed progression with varied dwell and errors
    begin
      int gp, gh, target, sel;
      logic [11:0] bus;
      gp = 0; gh = 0; target = 3;
      for (int n = 0; n < 4000; n++) begin
        sel = int'($urandom_range(0, 99));
        if (sel < 80) begin
          if (gh >= target) begin
            gp = (gp + 1) % 6;
            gh = 0;
            target = ($urandom_range(0, 9) < 8) ? 3 : int'($urandom_range(1, 4));
          end
          bus = legal_t[gp];
          gh++;
        end else if (sel < 88) begin
          bus = legal_t[$urandom_range(0, 5)];
        end else begin
          bus = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
        end
        drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) == 0), bus);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
